// File: rtl/inst_fetch.sv
// rtl/inst_fetch.sv - byte-serial instruction fetch: four byte reads assembled into one 32-bit word
// Holds the assembled word for IF_ID until accepted; an EX redirect aborts any fetch in progress.
module inst_fetch (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        stall_in,
  input  logic        jumpE_in,
  input  logic [31:0] jumpAddr_in,
  input  logic        memGrant_in,
  input  logic [7:0]  memData_in,
  output logic        memReq_out,
  output logic [31:0] memAddr_out,
  output logic [31:0] pc_out,
  output logic [31:0] inst_out,
  output logic        instValid_out
);

  typedef enum logic {FETCH, HOLD} state_t;

  state_t      state;
  state_t      state_nxt;
  logic [31:0] pc;
  logic [2:0]  issue_cnt;
  logic        pend_e;
  logic [1:0]  pend_idx;
  logic [31:0] inst_buf;
  logic        grant_take;
  logic        capture_last;
  logic        accept;

  // A redirect overrides both the final byte capture and a HOLD hand-off on the same edge.
  always_comb begin
    grant_take   = memReq_out & memGrant_in;
    capture_last = pend_e & (pend_idx == 2'd3) & ~jumpE_in;
    accept       = (state == HOLD) & ~stall_in & ~jumpE_in;
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) state <= FETCH;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (jumpE_in)          state_nxt = FETCH;
    else if (capture_last) state_nxt = HOLD;
    else if (accept)       state_nxt = FETCH;
  end

  always_comb begin
    memReq_out  = ~rst_in & (state == FETCH) & (issue_cnt < 3'd4) & ~jumpE_in;
    memAddr_out = memReq_out ? (pc + {29'd0, issue_cnt}) : 32'd0;
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      pc            <= 32'd0;
      issue_cnt     <= 3'd0;
      pend_e        <= 1'b0;
      pend_idx      <= 2'd0;
      inst_buf      <= 32'd0;
      pc_out        <= 32'd0;
      inst_out      <= 32'd0;
      instValid_out <= 1'b0;
    end else if (jumpE_in) begin
      pc            <= jumpAddr_in;
      issue_cnt     <= 3'd0;
      pend_e        <= 1'b0;
      instValid_out <= 1'b0;
    end else begin
      pend_e <= grant_take;
      if (grant_take) begin
        issue_cnt <= issue_cnt + 3'd1;
        pend_idx  <= issue_cnt[1:0];
      end
      // Data for a granted byte arrives one cycle later, independent of the current grant.
      if (pend_e)
        inst_buf[{pend_idx, 3'b000} +: 8] <= memData_in;
      if (capture_last) begin
        pc_out        <= pc;
        inst_out      <= {memData_in, inst_buf[23:0]};
        instValid_out <= 1'b1;
      end
      if (accept) begin
        pc            <= pc + 32'd4;
        issue_cnt     <= 3'd0;
        instValid_out <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_inst_fetch.sv
// tb/tb_inst_fetch.sv - self-checking bench for inst_fetch
module tb_inst_fetch;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        stall_in;
  logic        jumpE_in;
  logic [31:0] jumpAddr_in;
  logic        memGrant_in;
  logic [7:0]  memData_in;
  logic        memReq_out;
  logic [31:0] memAddr_out;
  logic [31:0] pc_out;
  logic [31:0] inst_out;
  logic        instValid_out;

  inst_fetch dut (
    .clk_in(clk_in), .rst_in(rst_in), .stall_in(stall_in), .jumpE_in(jumpE_in),
    .jumpAddr_in(jumpAddr_in), .memGrant_in(memGrant_in), .memData_in(memData_in),
    .memReq_out(memReq_out), .memAddr_out(memAddr_out), .pc_out(pc_out),
    .inst_out(inst_out), .instValid_out(instValid_out)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic [7:0]  gmask;
    int          stall_cyc;
    logic [31:0] pc;
    logic [31:0] inst;
    int          lat;
  } vec_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } exp_t;

  logic [7:0]  mem [512];
  exp_t        sb[$];
  exp_t        last_exp;
  vec_t        vecs[4];
  int          n_pass = 0;
  int          n_total = 0;
  logic        s_req, s_valid, prev_g;
  logic [31:0] s_addr, s_pc, s_inst, prev_a;

  function automatic logic [31:0] word(input logic [31:0] a);
    logic [8:0] i;
    i = a[8:0];
    return {mem[i + 9'd3], mem[i + 9'd2], mem[i + 9'd1], mem[i]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // One clock cycle: drive inputs, answer last cycle's granted read, sample at negedge.
  task automatic tick(input logic g, input logic st, input logic j, input logic [31:0] ja);
    memGrant_in = g;
    stall_in    = st;
    jumpE_in    = j;
    jumpAddr_in = ja;
    memData_in  = prev_g ? mem[prev_a[8:0]] : 8'($urandom);
    @(negedge clk_in);
    s_req   = memReq_out;
    s_addr  = memAddr_out;
    s_valid = instValid_out;
    s_pc    = pc_out;
    s_inst  = inst_out;
    prev_g  = memReq_out & g;
    prev_a  = memAddr_out;
    @(posedge clk_in);
    #1;
  endtask

  task automatic run_fetch(input logic [7:0] gm, input logic [31:0] epc, input logic [31:0] einst,
                           input int elat, input string tag);
    int issued;
    bit done;
    issued = 0;
    done = 0;
    sb.push_back('{epc, einst});
    for (int k = 0; k < 40 && !done; k++) begin
      tick(gm[k % 8], 1'b1, 1'b0, 32'd0);
      if (s_valid) begin
        done = 1;
        chk({tag, " latency"}, 32'(k), 32'(elat));
        chk({tag, " req in hold"}, 32'(s_req), 32'd0);
        if (sb.size() == 0) begin
          n_total++;
          $display("FAIL %s scoreboard: got valid expected none", tag);
        end else begin
          last_exp = sb.pop_front();
          chk({tag, " pc_out"}, s_pc, last_exp.pc);
          chk({tag, " inst_out"}, s_inst, last_exp.inst);
        end
      end else begin
        chk({tag, " req"}, 32'(s_req), 32'(issued < 4));
        if (s_req) chk({tag, " addr"}, s_addr, epc + 32'(issued));
        if (s_req && gm[k % 8]) issued++;
      end
    end
    if (!done) begin
      n_total++;
      $display("FAIL %s timeout: got no valid expected valid within 40 cycles", tag);
    end
  endtask

  task automatic hold_stall(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      tick(1'b1, 1'b1, 1'b0, 32'd0);
      chk({tag, " stall valid"}, 32'(s_valid), 32'd1);
      chk({tag, " stall req"}, 32'(s_req), 32'd0);
      chk({tag, " stall pc"}, s_pc, last_exp.pc);
      chk({tag, " stall inst"}, s_inst, last_exp.inst);
    end
  endtask

  task automatic release_hold(input string tag);
    tick(1'b1, 1'b0, 1'b0, 32'd0);
    chk({tag, " transfer valid"}, 32'(s_valid), 32'd1);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " req"}, 32'(memReq_out), 32'd0);
    chk({tag, " addr"}, memAddr_out, 32'd0);
    chk({tag, " pc_out"}, pc_out, 32'd0);
    chk({tag, " inst_out"}, inst_out, 32'd0);
    chk({tag, " valid"}, 32'(instValid_out), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 512; i++) mem[i] = 8'(i * 37 + 11);
    mem[0] = 8'h13; mem[1] = 8'h05; mem[2] = 8'h10; mem[3] = 8'h00;
    vecs[0] = '{8'hFF, 3, 32'h0, 32'h00100513, 5};
    vecs[1] = '{8'h55, 0, 32'h4, word(32'h4), 8};
    vecs[2] = '{8'hAA, 1, 32'h8, word(32'h8), 9};
    vecs[3] = '{8'h11, 0, 32'hC, word(32'hC), 14};

    rst_in = 1'b1; stall_in = 1'b1; jumpE_in = 1'b0; jumpAddr_in = 32'd0;
    memGrant_in = 1'b0; memData_in = 8'd0; prev_g = 1'b0; prev_a = 32'd0;
    @(posedge clk_in);
    #1;
    chk_zero("reset");
    rst_in = 1'b0;

    for (int v = 0; v < 4; v++) begin
      run_fetch(vecs[v].gmask, vecs[v].pc, vecs[v].inst, vecs[v].lat, $sformatf("vec%0d", v));
      hold_stall(vecs[v].stall_cyc, $sformatf("vec%0d", v));
      release_hold($sformatf("vec%0d", v));
    end

    // Redirect after two bytes of the fetch at 0x10 were granted.
    tick(1'b1, 1'b1, 1'b0, 32'd0);
    tick(1'b1, 1'b1, 1'b0, 32'd0);
    tick(1'b1, 1'b1, 1'b1, 32'h100);
    chk("jump req suppressed", 32'(s_req), 32'd0);
    run_fetch(8'hFF, 32'h100, word(32'h100), 5, "jump mid");
    release_hold("jump mid");

    // Redirect on the edge that would capture byte 3.
    for (int i = 0; i < 4; i++) tick(1'b1, 1'b1, 1'b0, 32'd0);
    tick(1'b1, 1'b1, 1'b1, 32'h40);
    chk("jump at b3 valid", 32'(s_valid), 32'd0);
    run_fetch(8'hFF, 32'h40, word(32'h40), 5, "jump b3");

    // Redirect while HOLD is being accepted; unaligned target.
    tick(1'b0, 1'b0, 1'b1, 32'h1F3);
    chk("jump hold valid", 32'(s_valid), 32'd1);
    run_fetch(8'hFF, 32'h1F3, word(32'h1F3), 5, "jump hold");
    release_hold("jump hold");

    // Reset pulse between edges mid-fetch.
    tick(1'b1, 1'b1, 1'b0, 32'd0);
    tick(1'b1, 1'b1, 1'b0, 32'd0);
    memGrant_in = 1'b0;
    rst_in = 1'b1;
    #2;
    chk_zero("midreset");
    rst_in = 1'b0;
    @(negedge clk_in);
    chk("midreset restart req", 32'(memReq_out), 32'd1);
    chk("midreset restart addr", memAddr_out, 32'd0);
    @(posedge clk_in);
    #1;
    prev_g = 1'b0;
    run_fetch(8'hFF, 32'h0, 32'h00100513, 5, "after reset");
    release_hold("after reset");

    // Same word at 0 fetched with alternating grants.
    tick(1'b0, 1'b1, 1'b1, 32'h0);
    run_fetch(8'h55, 32'h0, 32'h00100513, 8, "alt grant");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
